// File: rtl/mram_read_pts_pkg.sv
// rtl/mram_read_pts_pkg.sv - shared types and constants for the MRAM read return serializer
package mram_read_pts_pkg;

    localparam int DATA_W   = 16;
    localparam int BYTE_LEN = 8;
    localparam int WORD_LEN = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SHIFT = 2'd2,
        PAR   = 2'd3
    } pts_state_e;

    typedef enum logic [1:0] {
        FULL  = 2'd0,
        LOWER = 2'd1,
        UPPER = 2'd2,
        NONE  = 2'd3
    } byte_mode_e;

    // Byte enables are active low; both high means nothing to return.
    function automatic byte_mode_e decode_mode(input logic lower_n, input logic upper_n);
        case ({upper_n, lower_n})
            2'b00:   return FULL;
            2'b10:   return LOWER;
            2'b01:   return UPPER;
            default: return NONE;
        endcase
    endfunction

endpackage

// File: rtl/mram_read_pts_if.sv
// rtl/mram_read_pts_if.sv - controller/data-pin side and serial return side of the read serializer
interface mram_read_pts_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 5
);
    logic              load;
    logic              en;
    logic              send;
    logic              lower_byte_en_n;
    logic              upper_byte_en_n;
    logic [DATA_W-1:0] mram_dq;
    logic              serial_out;
    logic              serial_valid;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  bit_cnt;

    modport master (
        output load, en, send, lower_byte_en_n, upper_byte_en_n, mram_dq,
        input  serial_out, serial_valid, busy, done, bit_cnt
    );

    modport slave (
        input  load, en, send, lower_byte_en_n, upper_byte_en_n, mram_dq,
        output serial_out, serial_valid, busy, done, bit_cnt
    );
endinterface

// File: rtl/mram_read_pts.sv
// rtl/mram_read_pts.sv - MRAM read data parallel-to-serial return path; MRAM_PTS_PARITY_EN adds a trailing parity bit
module mram_read_pts
    import mram_read_pts_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 5
) (
    input  logic           clk,
    input  logic           rst,
    mram_read_pts_if.slave bus
);

`ifdef MRAM_PTS_PARITY_EN
    localparam logic       PAR_EN         = 1'b1;
    localparam pts_state_e LAST_DATA_NEXT = PAR;
`else
    localparam logic       PAR_EN         = 1'b0;
    localparam pts_state_e LAST_DATA_NEXT = IDLE;
`endif

    pts_state_e        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sout_q, sout_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef MRAM_PTS_PARITY_EN
    logic              par_q, par_d;
`endif

    byte_mode_e        mode;
    logic              do_load;
    logic              do_step;
    logic              last_bit;
    logic [DATA_W-1:0] capture;
    logic [CNT_W-1:0]  cap_len;

    always_comb begin
        mode     = decode_mode(bus.lower_byte_en_n, bus.upper_byte_en_n);
        do_load  = bus.load && (mode != NONE);
        do_step  = bus.en && bus.send;
        last_bit = (cnt_q + 1'b1) == len_q;
        capture  = '0;
        cap_len  = '0;
        // Selected lane is left-justified so the shifter always drains from bit DATA_W-1.
        case (mode)
            FULL: begin
                capture = bus.mram_dq;
                cap_len = CNT_W'(WORD_LEN);
            end
            LOWER: begin
                capture = {bus.mram_dq[BYTE_LEN-1:0], {BYTE_LEN{1'b0}}};
                cap_len = CNT_W'(BYTE_LEN);
            end
            UPPER: begin
                capture = {bus.mram_dq[DATA_W-1:BYTE_LEN], {BYTE_LEN{1'b0}}};
                cap_len = CNT_W'(BYTE_LEN);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            sout_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MRAM_PTS_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            sout_q  <= sout_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MRAM_PTS_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        if (do_load) begin
            state_d = ARMED;
        end else begin
            case (state_q)
                ARMED, SHIFT: if (do_step) state_d = last_bit ? LAST_DATA_NEXT : SHIFT;
`ifdef MRAM_PTS_PARITY_EN
                PAR:          if (do_step) state_d = IDLE;
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        shift_d = shift_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        sout_d  = sout_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef MRAM_PTS_PARITY_EN
        par_d   = par_q;
`endif
        if (do_load) begin
            shift_d = capture;
            len_d   = cap_len;
            cnt_d   = '0;
            busy_d  = 1'b1;
`ifdef MRAM_PTS_PARITY_EN
            par_d   = ^capture;
`endif
        end else if (do_step) begin
            case (state_q)
                ARMED, SHIFT: begin
                    sout_d  = shift_q[DATA_W-1];
                    shift_d = {shift_q[DATA_W-2:0], 1'b0};
                    cnt_d   = cnt_q + 1'b1;
                    valid_d = 1'b1;
                    if (last_bit && !PAR_EN) begin
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end
                end
`ifdef MRAM_PTS_PARITY_EN
                PAR: begin
                    sout_d  = par_q;
                    cnt_d   = cnt_q + 1'b1;
                    valid_d = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.serial_out   = sout_q;
    assign bus.serial_valid = valid_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.bit_cnt      = cnt_q;

endmodule

// File: tb/tb_mram_read_pts.sv
// tb/tb_mram_read_pts.sv - self-checking bench for mram_read_pts with a bit-queue reference model
module tb_mram_read_pts;

`ifdef MRAM_PTS_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mram_read_pts_if #(.DATA_W(16), .CNT_W(5)) bus ();

    mram_read_pts #(.DATA_W(16), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the word is a queue of bits still to be sent.
    logic     mq[$];
    logic     m_sout, m_valid, m_busy, m_done;
    int       m_cnt;

    logic [31:0] rx;
    int          rx_n;
    int          n_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_sout = 0; m_valid = 0; m_busy = 0; m_done = 0; m_cnt = 0;
    endtask

    task automatic model_step(input logic ld, input logic e, input logic s,
                              input logic lo_n, input logic up_n, input logic [15:0] dq);
        logic p;
        m_valid = 0;
        m_done  = 0;
        if (ld && !(lo_n && up_n)) begin
            mq.delete();
            if (!up_n) for (int i = 15; i >= 8; i--) mq.push_back(dq[i]);
            if (!lo_n) for (int i = 7; i >= 0; i--) mq.push_back(dq[i]);
            if (PAR != 0) begin
                p = 0;
                foreach (mq[i]) p = p ^ mq[i];
                mq.push_back(p);
            end
            m_cnt  = 0;
            m_busy = 1;
        end else if (m_busy && e && s) begin
            m_sout  = mq.pop_front();
            m_valid = 1;
            m_cnt++;
            if (mq.size() == 0) begin
                m_done = 1;
                m_busy = 0;
            end
        end
    endtask

    task automatic compare_outputs();
        check("serial_out",   32'(bus.serial_out),   32'(m_sout));
        check("serial_valid", 32'(bus.serial_valid), 32'(m_valid));
        check("busy",         32'(bus.busy),         32'(m_busy));
        check("done",         32'(bus.done),         32'(m_done));
        check("bit_cnt",      32'(bus.bit_cnt),      32'(m_cnt));
        if (bus.serial_valid === 1'b1) begin
            rx = {rx[30:0], bus.serial_out};
            rx_n++;
        end
        if (bus.done === 1'b1) n_done++;
    endtask

    task automatic cycle(input logic ld, input logic e, input logic s,
                         input logic lo_n, input logic up_n, input logic [15:0] dq);
        bus.load = ld; bus.en = e; bus.send = s;
        bus.lower_byte_en_n = lo_n; bus.upper_byte_en_n = up_n; bus.mram_dq = dq;
        @(posedge clk);
        model_step(ld, e, s, lo_n, up_n, dq);
        #1;
        compare_outputs();
    endtask

    task automatic send_n(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0);
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0);
    endtask

    task automatic rx_clear();
        rx = '0; rx_n = 0; n_done = 0;
    endtask

    initial begin
        logic e, s, ld, lo_n, up_n;
        logic [15:0] dq;
        int guard;

        bus.load = 0; bus.en = 0; bus.send = 0;
        bus.lower_byte_en_n = 1; bus.upper_byte_en_n = 1; bus.mram_dq = '0;
        model_reset();
        rx_clear();
        #1;
        compare_outputs();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        idle_n(2);

        // Full word, continuous send
        rx_clear();
        cycle(1, 0, 0, 0, 0, 16'hA5C3);
        send_n(16 + PAR + 2);
        check("full_bits",  rx, (PAR != 0) ? 32'h14B86 : 32'hA5C3);
        check("full_count", 32'(rx_n), 32'(16 + PAR));
        check("full_done",  32'(n_done), 32'd1);

        // Lower byte only
        rx_clear();
        cycle(1, 0, 0, 0, 1, 16'h1234);
        send_n(8 + PAR + 2);
        check("lower_bits",  rx, (PAR != 0) ? 32'h69 : 32'h34);
        check("lower_count", 32'(rx_n), 32'(8 + PAR));
        check("lower_cnt",   32'(bus.bit_cnt), 32'(8 + PAR));

        // Upper byte only
        rx_clear();
        cycle(1, 0, 0, 1, 0, 16'h1234);
        send_n(8 + PAR + 2);
        check("upper_bits",  rx, (PAR != 0) ? 32'h24 : 32'h12);
        check("upper_count", 32'(rx_n), 32'(8 + PAR));

        // Load with no lane selected is ignored
        rx_clear();
        cycle(1, 0, 0, 1, 1, 16'hBEEF);
        send_n(4);
        check("none_busy",  32'(bus.busy), 32'd0);
        check("none_count", 32'(rx_n), 32'd0);

        // Stall for three cycles after bit 5
        rx_clear();
        cycle(1, 0, 0, 0, 0, 16'hFFFF);
        send_n(5);
        cycle(0, 1, 0, 1, 1, 16'h0);
        cycle(0, 0, 1, 1, 1, 16'h0);
        cycle(0, 0, 0, 1, 1, 16'h0);
        send_n(11 + PAR + 2);
        check("stall_bits",  rx, (PAR != 0) ? 32'h1FFFE : 32'hFFFF);
        check("stall_count", 32'(rx_n), 32'(16 + PAR));

        // Reload mid-word with send still asserted
        rx_clear();
        cycle(1, 0, 0, 0, 0, 16'hA5C3);
        send_n(4);
        rx_clear();
        cycle(1, 1, 1, 0, 0, 16'h00FF);
        send_n(16 + PAR + 2);
        check("reload_bits", rx, (PAR != 0) ? 32'h1FE : 32'h00FF);
        check("reload_done", 32'(n_done), 32'd1);

        // Parity-sensitive word
        rx_clear();
        cycle(1, 0, 0, 0, 0, 16'h0001);
        send_n(16 + PAR + 2);
        check("one_bits", rx, (PAR != 0) ? 32'h3 : 32'h1);

        // Asynchronous reset mid-word
        cycle(1, 0, 0, 0, 0, 16'hA5C3);
        send_n(5);
        rst = 1;
        model_reset();
        #1;
        compare_outputs();
        @(posedge clk);
        #1;
        rst = 0;
        compare_outputs();
        idle_n(1);

        // Randomized traffic with stalls and occasional reloads
        for (int t = 0; t < 40; t++) begin
            dq   = 16'($urandom);
            lo_n = 1'($urandom_range(0, 1));
            up_n = (lo_n == 1'b1) ? 1'b0 : 1'($urandom_range(0, 1));
            cycle(1, 0, 0, lo_n, up_n, dq);
            guard = 0;
            while (m_busy && guard < 200) begin
                e  = ($urandom_range(0, 3) != 0);
                s  = ($urandom_range(0, 3) != 0);
                ld = ($urandom_range(0, 40) == 0);
                lo_n = 1'($urandom_range(0, 1));
                up_n = 1'($urandom_range(0, 1));
                cycle(ld, e, s, lo_n, up_n, 16'($urandom));
                guard++;
            end
            check("rand_drained", 32'(m_busy), 32'd0);
            idle_n($urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mram_read_pts.md
# mram_read_pts

Parallel-to-serial return path for MRAM reads. Captures the 16-bit MRAM data bus when the read controller pulses `load`, keeps only the byte lanes selected by the active-low byte enables, and shifts the kept bits out MSB-first while the controller holds its serial enable and send strobe. It sits between the MRAM data pins and the host serial return line, directly downstream of the read/write control sequencer.

## Interface
- `DATA_W`, 16, MRAM data bus width; must be 16.
- `CNT_W`, 5, bit-counter width; must satisfy 2^CNT_W > DATA_W+1.
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `load`  in  1  capture strobe from controller
- `en`  in  1  serial-out enable from controller (`data_in_from_MRAM_en`)
- `send`  in  1  shift strobe from controller (`send_data`)
- `lower_byte_en_n`  in  1  active low; bits 7:0 selected; sampled on `load`
- `upper_byte_en_n`  in  1  active low; bits 15:8 selected; sampled on `load`
- `mram_dq`  in  DATA_W  MRAM read data
- `serial_out`  out  1  serial data bit, registered
- `serial_valid`  out  1  `serial_out` holds a real bit this cycle
- `busy`  out  1  word captured and not yet fully sent
- `done`  out  1  one-cycle pulse on last transmitted bit
- `bit_cnt`  out  CNT_W  bits sent of current word

## Operation
- States: IDLE, ARMED, SHIFT, PAR (PAR exists only with the macro defined).
- Reset and power-up values: all outputs 0, state IDLE, shift register 0, length 0.
- `load`=1 in any state with at least one enable low: capture and go to ARMED, `bit_cnt`=0, `busy`=1. Lane selection:
  - Both enables low: shift register = `mram_dq`, length 16.
  - Lower only: shift register = {`mram_dq`[7:0], 8'h00}, length 8.
  - Upper only: shift register = {`mram_dq`[15:8], 8'h00}, length 8.
- `load` with both enables high: ignored, no state change.
- ARMED -> SHIFT on the first edge with `en`&&`send`.
- In ARMED and SHIFT, each edge with `en`&&`send`: `serial_out` <= shift register MSB, shift left with zero fill, `bit_cnt`+1, `serial_valid`=1.
- Any other edge: `serial_valid`=0; `serial_out`, register and count hold (stall). `en` low mid-word pauses the shift; it does not abort.
- Last data bit (`bit_cnt` reaching length): `done`=1 with that bit. Go to IDLE, `busy`=0, `bit_cnt` holds its final value until the next load.
- `load` during SHIFT has priority: recapture and restart the word. No `done` is issued for the aborted word.
- `rst` mid-word: immediate return to reset values.

## Timing
- Capture latency: data is in the register on the edge that samples `load`=1.
- The first bit appears on `serial_out` one clock after the first edge sampling `en`&&`send`.
- A 16-bit word with an uninterrupted strobe takes 16 valid cycles. An 8-bit word takes 8.
- `done` and `serial_valid` are both high during the last bit's cycle.
- This alignment matches the controller: `load` falls the cycle after `send` rises, and the 8-bit case ends at controller count 31 while the 16-bit case ends at count 39.
- No combinational path from any input to any output.

## Configuration
- `MRAM_PTS_PARITY_EN`
  - Defined: the even parity bit over the transmitted data bits (XOR of the sent bits) is captured at `load`. After the last data bit, state PAR sends it as one extra valid bit on the next `en`&&`send` edge. `done` moves to the parity cycle, and `bit_cnt` ends at length+1.
  - Undefined: no PAR state and no extra bit; `done` comes with the last data bit.

## Structure
- Shared package holds:
  - the state enum (IDLE, ARMED, SHIFT, PAR);
  - the byte-mode encoding (FULL, LOWER, UPPER, NONE);
  - the constants `DATA_W`=16, `BYTE_LEN`=8, `WORD_LEN`=16.
- No sub-module: parity is an inline XOR reduction and the shifter is a single register.

## Test plan
- Both enables low, `mram_dq`=16'hA5C3, load then continuous `send` -> `serial_out` 1010010111000011, 16 valid cycles, `done` with the 16th bit.
- Lower only, `mram_dq`=16'h1234 -> 00110100, 8 valid cycles, `done` on the 8th, `bit_cnt`=8.
- Upper only, 16'h1234 -> 00010010. Both enables high with `load` -> no `busy`, no valid bits.
- Full word 16'hFFFF with `send` low for 3 cycles after bit 5 -> `serial_valid` low for those 3 cycles, data resumes with bit 6, 16 bits total.
- Relaod 16'h00FF at bit 4 of 16'hA5C3 -> no `done` for the first word, 00000000 11111111 follows. Assert `rst` mid-word -> all outputs 0 next cycle.
- With `MRAM_PTS_PARITY_EN`: 16'hA5C3 -> 17th bit 0; 16'h0001 -> 17th bit 1; `done` on bit 17.
